// File: rtl/alarma_carro_if.sv
// Key-fob/sensor inputs and status outputs of the car-alarm sequencer.
// master drives requests and sensors; slave is the alarm FSM.
interface alarma_carro_if #(
   parameter int unsigned N_ZONES = 4
) ();
   logic               arm_req;
   logic               disarm_req;
   logic [N_ZONES-1:0] zone_mask;
   logic [N_ZONES-1:0] zones;
   logic [2:0]         state;
   logic               siren;
   logic               led;
   logic [N_ZONES-1:0] tripped_zones;
   logic [7:0]         trip_count;
   logic               arm_fault;
   logic               chirp;

   modport master (
      output arm_req, disarm_req, zone_mask, zones,
      input  state, siren, led, tripped_zones, trip_count, arm_fault, chirp
   );

   modport slave (
      input  arm_req, disarm_req, zone_mask, zones,
      output state, siren, led, tripped_zones, trip_count, arm_fault, chirp
   );
endinterface

// File: rtl/alarma_carro_fsm.sv
// Car-alarm sequencer: exit delay, entry delay, timed siren, auto re-arm.
// Define ALARMA_CHIRP_EN to enable arm/disarm confirmation chirps.
module alarma_carro_fsm #(
   parameter int unsigned N_ZONES   = 4,
   parameter int unsigned EXIT_DLY  = 8,
   parameter int unsigned ENTRY_DLY = 8,
   parameter int unsigned SIREN_CYC = 16,
   parameter int unsigned TMR_W     = 8
) (
   input logic              clk,
   input logic              reset,
   alarma_carro_if.slave    io
);

   localparam int unsigned ST_W = 3;
   localparam int unsigned CNT_W = 8;

   localparam logic [ST_W-1:0] S_DISARMED = 3'd0;
   localparam logic [ST_W-1:0] S_ARMING   = 3'd1;
   localparam logic [ST_W-1:0] S_ARMED    = 3'd2;
   localparam logic [ST_W-1:0] S_ENTRY    = 3'd3;
   localparam logic [ST_W-1:0] S_ALARM    = 3'd4;

`ifdef ALARMA_CHIRP_EN
   localparam logic CHIRP_EN = 1'b1;
`else
   localparam logic CHIRP_EN = 1'b0;
`endif

   logic [ST_W-1:0]    r_state;
   logic [TMR_W-1:0]   r_timer;
   logic [N_ZONES-1:0] r_tripped;
   logic [CNT_W-1:0]   r_count;
   logic               r_fault;
   logic               r_chirp;
   logic               r_siren;
   logic               r_led;

   logic [N_ZONES-1:0] w_open;
   logic [ST_W-1:0]    w_state_nxt;
   logic [TMR_W-1:0]   w_timer_nxt;
   logic [N_ZONES-1:0] w_tripped_nxt;
   logic [CNT_W-1:0]   w_count_nxt;
   logic               w_fault_nxt;
   logic               w_chirp_ev;
   logic               w_chirp_nxt;
   logic               w_siren_nxt;
   logic               w_led_nxt;

   assign w_open = io.zones & io.zone_mask;

   // State register; status outputs are registered alongside it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_DISARMED;
         r_timer   <= '0;
         r_tripped <= '0;
         r_count   <= '0;
         r_fault   <= 1'b0;
         r_chirp   <= 1'b0;
         r_siren   <= 1'b0;
         r_led     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_timer   <= w_timer_nxt;
         r_tripped <= w_tripped_nxt;
         r_count   <= w_count_nxt;
         r_fault   <= w_fault_nxt;
         r_chirp   <= w_chirp_nxt;
         r_siren   <= w_siren_nxt;
         r_led     <= w_led_nxt;
      end
   end

   // Next-state logic; disarm overrides every state except DISARMED.
   always_comb begin
      w_state_nxt   = r_state;
      w_timer_nxt   = r_timer;
      w_tripped_nxt = r_tripped;
      w_count_nxt   = r_count;
      w_fault_nxt   = 1'b0;
      w_chirp_ev    = 1'b0;
      if (io.disarm_req && (r_state != S_DISARMED)) begin
         w_state_nxt = S_DISARMED;
         w_timer_nxt = '0;
         w_chirp_ev  = 1'b1;
      end else begin
         case (r_state)
            S_DISARMED: begin
               if (io.arm_req) begin
                  w_state_nxt   = S_ARMING;
                  w_timer_nxt   = TMR_W'(EXIT_DLY - 1);
                  w_tripped_nxt = '0;
               end
            end
            S_ARMING: begin
               if (r_timer == '0) begin
                  if (w_open == '0) begin
                     w_state_nxt = S_ARMED;
                     w_chirp_ev  = 1'b1;
                  end else begin
                     w_state_nxt = S_DISARMED;
                     w_fault_nxt = 1'b1;
                  end
               end else begin
                  w_timer_nxt = r_timer - TMR_W'(1);
               end
            end
            S_ARMED: begin
               if (w_open != '0) begin
                  w_state_nxt   = S_ENTRY;
                  w_timer_nxt   = TMR_W'(ENTRY_DLY - 1);
                  w_tripped_nxt = r_tripped | w_open;
               end
            end
            S_ENTRY: begin
               w_tripped_nxt = r_tripped | w_open;
               if (r_timer == '0) begin
                  w_state_nxt = S_ALARM;
                  w_timer_nxt = TMR_W'(SIREN_CYC - 1);
                  if (r_count != '1) w_count_nxt = r_count + CNT_W'(1);
               end else begin
                  w_timer_nxt = r_timer - TMR_W'(1);
               end
            end
            S_ALARM: begin
               w_tripped_nxt = r_tripped | w_open;
               if (r_timer == '0) w_state_nxt = S_ARMED;
               else               w_timer_nxt = r_timer - TMR_W'(1);
            end
            default: begin
               w_state_nxt = S_DISARMED;
               w_timer_nxt = '0;
            end
         endcase
      end
   end

   // Output decode from the upcoming state so the registered outputs track it.
   always_comb begin
      w_siren_nxt = 1'b0;
      w_led_nxt   = 1'b0;
      w_chirp_nxt = CHIRP_EN & w_chirp_ev;
      case (w_state_nxt)
         S_ARMED:            w_led_nxt = 1'b1;
         S_ALARM: begin
            w_led_nxt   = 1'b1;
            w_siren_nxt = 1'b1;
         end
         S_ARMING, S_ENTRY:  w_led_nxt = w_timer_nxt[0];
         default:            w_led_nxt = 1'b0;
      endcase
   end

   assign io.state         = r_state;
   assign io.siren         = r_siren;
   assign io.led           = r_led;
   assign io.tripped_zones = r_tripped;
   assign io.trip_count    = r_count;
   assign io.arm_fault     = r_fault;
   assign io.chirp         = r_chirp;

endmodule
